// File: rtl/mcpu_core_wb_loadq_if.sv
// Signal bundle between execute/memory and the writeback load queue.
// master drives lane results and load returns; slave is the writeback block.
interface mcpu_core_wb_loadq_if #(
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]  ex2wb_rd_num0,  ex2wb_rd_num1,  ex2wb_rd_num2,  ex2wb_rd_num3;
    logic [31:0] ex2wb_rd_data0, ex2wb_rd_data1, ex2wb_rd_data2, ex2wb_rd_data3;
    logic        ex2wb_rd_we0,   ex2wb_rd_we1,   ex2wb_rd_we2,   ex2wb_rd_we3;
    logic        ex2wb_pred_we0, ex2wb_pred_we1, ex2wb_pred_we2, ex2wb_pred_we3;

    logic        mem2wb_valid;
    logic        mem2wb_ready;
    logic [4:0]  mem2wb_rd_num;
    logic [31:0] mem2wb_data;

    logic [4:0]  wb2rf_rd_num0,  wb2rf_rd_num1,  wb2rf_rd_num2,  wb2rf_rd_num3;
    logic [31:0] wb2rf_rd_data0, wb2rf_rd_data1, wb2rf_rd_data2, wb2rf_rd_data3;
    logic        wb2rf_rd_we0,   wb2rf_rd_we1,   wb2rf_rd_we2,   wb2rf_rd_we3;
    logic        wb2rf_pred_we0, wb2rf_pred_we1, wb2rf_pred_we2, wb2rf_pred_we3;

    logic [31:0] wb2d_pending;
    logic [PW:0] wb2d_q_count;

    modport master (
        output ex2wb_rd_num0,  ex2wb_rd_num1,  ex2wb_rd_num2,  ex2wb_rd_num3,
        output ex2wb_rd_data0, ex2wb_rd_data1, ex2wb_rd_data2, ex2wb_rd_data3,
        output ex2wb_rd_we0,   ex2wb_rd_we1,   ex2wb_rd_we2,   ex2wb_rd_we3,
        output ex2wb_pred_we0, ex2wb_pred_we1, ex2wb_pred_we2, ex2wb_pred_we3,
        output mem2wb_valid, mem2wb_rd_num, mem2wb_data,
        input  mem2wb_ready,
        input  wb2rf_rd_num0,  wb2rf_rd_num1,  wb2rf_rd_num2,  wb2rf_rd_num3,
        input  wb2rf_rd_data0, wb2rf_rd_data1, wb2rf_rd_data2, wb2rf_rd_data3,
        input  wb2rf_rd_we0,   wb2rf_rd_we1,   wb2rf_rd_we2,   wb2rf_rd_we3,
        input  wb2rf_pred_we0, wb2rf_pred_we1, wb2rf_pred_we2, wb2rf_pred_we3,
        input  wb2d_pending, wb2d_q_count
    );

    modport slave (
        input  ex2wb_rd_num0,  ex2wb_rd_num1,  ex2wb_rd_num2,  ex2wb_rd_num3,
        input  ex2wb_rd_data0, ex2wb_rd_data1, ex2wb_rd_data2, ex2wb_rd_data3,
        input  ex2wb_rd_we0,   ex2wb_rd_we1,   ex2wb_rd_we2,   ex2wb_rd_we3,
        input  ex2wb_pred_we0, ex2wb_pred_we1, ex2wb_pred_we2, ex2wb_pred_we3,
        input  mem2wb_valid, mem2wb_rd_num, mem2wb_data,
        output mem2wb_ready,
        output wb2rf_rd_num0,  wb2rf_rd_num1,  wb2rf_rd_num2,  wb2rf_rd_num3,
        output wb2rf_rd_data0, wb2rf_rd_data1, wb2rf_rd_data2, wb2rf_rd_data3,
        output wb2rf_rd_we0,   wb2rf_rd_we1,   wb2rf_rd_we2,   wb2rf_rd_we3,
        output wb2rf_pred_we0, wb2rf_pred_we1, wb2rf_pred_we2, wb2rf_pred_we3,
        output wb2d_pending, wb2d_q_count
    );
endinterface

// File: rtl/mcpu_core_wb_loadq.sv
// Writeback stage: registers the four execute lanes into the regfile ports and drains
// queued load returns into idle lanes. Define WB_BYPASS_EN to let a load skip an empty queue.
module mcpu_core_wb_loadq #(
    parameter int DEPTH = 4
) (
    input logic                 clkrst_core_clk,
    input logic                 clkrst_core_rst,
    mcpu_core_wb_loadq_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int LANES = 4;

    logic [LANES-1:0][4:0]  lane_rd;
    logic [LANES-1:0][31:0] lane_data;
    logic [LANES-1:0]       lane_we;
    logic [LANES-1:0]       lane_pwe;

    assign lane_rd   = {bus.ex2wb_rd_num3,  bus.ex2wb_rd_num2,  bus.ex2wb_rd_num1,  bus.ex2wb_rd_num0};
    assign lane_data = {bus.ex2wb_rd_data3, bus.ex2wb_rd_data2, bus.ex2wb_rd_data1, bus.ex2wb_rd_data0};
    assign lane_we   = {bus.ex2wb_rd_we3,   bus.ex2wb_rd_we2,   bus.ex2wb_rd_we1,   bus.ex2wb_rd_we0};
    assign lane_pwe  = {bus.ex2wb_pred_we3, bus.ex2wb_pred_we2, bus.ex2wb_pred_we1, bus.ex2wb_pred_we0};

    logic [4:0]  q_rd   [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic [LANES-1:0][4:0]  out_rd;
    logic [LANES-1:0][31:0] out_data;
    logic [LANES-1:0]       out_we;
    logic [LANES-1:0]       out_pwe;

    logic [LANES-1:0] idle;
    logic             any_idle;
    logic             ready;
    logic             push;
    logic             byp;
    logic             cand_valid;
    logic [4:0]       cand_rd;
    logic [31:0]      cand_data;
    logic             squash;
    logic             wr_en;
    logic [1:0]       wr_lane;
    logic             pop;
    logic             enq;
    logic [31:0]      pending;
    logic [PW-1:0]    offs;

    // Drain candidate is the queue head, or the arriving load when it bypasses an empty queue.
    always_comb begin
        // NOTE: every signal gets a default before any conditional code so no latch is inferred.
        idle       = ~(lane_we | lane_pwe);
        any_idle   = |idle;
        ready      = count < (PW+1)'(DEPTH);
        push       = bus.mem2wb_valid && ready;
`ifdef WB_BYPASS_EN
        byp        = push && (count == '0);
`else
        byp        = 1'b0;
`endif
        cand_valid = (count != '0) || byp;
        cand_rd    = byp ? bus.mem2wb_rd_num : q_rd[head];
        cand_data  = byp ? bus.mem2wb_data   : q_data[head];

        squash = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k] && (lane_rd[k] == cand_rd)) squash = 1'b1;
        end
        squash = squash && cand_valid;

        wr_lane = 2'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (idle[k]) wr_lane = 2'(k);
        end

        wr_en = cand_valid && !squash && any_idle;
        pop   = !byp && (count != '0) && (squash || any_idle);
        // A bypassing load is consumed unless every lane is busy and nothing squashes it.
        enq   = push && !(byp && (squash || any_idle));
    end

    // Pending mask reflects only registered queue contents.
    always_comb begin
        pending = '0;
        offs    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if ((PW+1)'(offs) < count) pending[q_rd[i]] = 1'b1;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (clkrst_core_rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            out_rd   <= '0;
            out_data <= '0;
            out_we   <= '0;
            out_pwe  <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            out_rd   <= lane_rd;
            out_data <= lane_data;
            out_we   <= lane_we;
            out_pwe  <= lane_pwe;
            if (wr_en) begin
                out_we[wr_lane]   <= 1'b1;
                out_pwe[wr_lane]  <= 1'b0;
                out_rd[wr_lane]   <= cand_rd;
                out_data[wr_lane] <= cand_data;
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only observed through count, which is reset.
    always_ff @(posedge clkrst_core_clk) begin
        if (enq) begin
            q_rd[tail]   <= bus.mem2wb_rd_num;
            q_data[tail] <= bus.mem2wb_data;
        end
    end

    assign bus.mem2wb_ready = ready;
    assign bus.wb2d_pending = pending;
    assign bus.wb2d_q_count = count;

    assign bus.wb2rf_rd_num0  = out_rd[0];
    assign bus.wb2rf_rd_num1  = out_rd[1];
    assign bus.wb2rf_rd_num2  = out_rd[2];
    assign bus.wb2rf_rd_num3  = out_rd[3];
    assign bus.wb2rf_rd_data0 = out_data[0];
    assign bus.wb2rf_rd_data1 = out_data[1];
    assign bus.wb2rf_rd_data2 = out_data[2];
    assign bus.wb2rf_rd_data3 = out_data[3];
    assign bus.wb2rf_rd_we0   = out_we[0];
    assign bus.wb2rf_rd_we1   = out_we[1];
    assign bus.wb2rf_rd_we2   = out_we[2];
    assign bus.wb2rf_rd_we3   = out_we[3];
    assign bus.wb2rf_pred_we0 = out_pwe[0];
    assign bus.wb2rf_pred_we1 = out_pwe[1];
    assign bus.wb2rf_pred_we2 = out_pwe[2];
    assign bus.wb2rf_pred_we3 = out_pwe[3];
endmodule
